operand_state_sequencer: RTL and testbench

OPERAND_STATE_SEQUENCER -- requirements
Module: operand_state_sequencer

---
 rtl/cpu_pkg.sv | 52 +++++
 rtl/operand_state_sequencer_pkg.sv | 19 +
 rtl/operand_state_sequencer_if.sv | 28 ++
 rtl/next_state_detector.sv | 51 +++++
 rtl/operand_state_sequencer.sv | 70 +++++++
 tb/tb_operand_state_sequencer.sv | 200 ++++++++++++++++++++
 6 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU types: controller states and opcode addressing modes.
package cpu_pkg;

   // Two encodings are left unused so illegal-state recovery is reachable.
   typedef enum logic [3:0] {
      S_FETCH_OPCODE   = 4'd0,
      S_FETCH_OPRAND_L = 4'd1,
      S_FETCH_OPRAND_H = 4'd2,
      S_FETCH_OPRAND_B = 4'd3,
      S_FETCH_BANK_1   = 4'd4,
      S_FETCH_BANK_2   = 4'd5,
      S_PC_INC         = 4'd6,
      S_PUSH_H         = 4'd7,
      S_PUSH_L         = 4'd8,
      S_PULL_P         = 4'd9,
      S_PULL_L         = 4'd10,
      S_PULL_H         = 4'd11,
      S_PULL_B         = 4'd12,
      S_OP_CALC        = 4'd13
   } state_type;

   typedef enum logic [4:0] {
      A_WAIT     = 5'd0,
      A_IMP      = 5'd1,
      A_IMM      = 5'd2,
      A_DP       = 5'd3,
      A_DPX      = 5'd4,
      A_ABS      = 5'd5,
      A_ABSX     = 5'd6,
      A_ABSY     = 5'd7,
      A_ABS_JMP  = 5'd8,
      A_ABSL     = 5'd9,
      A_ABSLX    = 5'd10,
      A_ABSL_JMP = 5'd11,
      A_SUB_IMM  = 5'd12,
      A_SUB_IMML = 5'd13,
      A_SUB_ABSX = 5'd14,
      A_PEA      = 5'd15,
      A_PER      = 5'd16,
      A_PUSH_DP  = 5'd17,
      A_PULL_A   = 5'd18,
      A_PULL_X   = 5'd19,
      A_PULL_Y   = 5'd20,
      A_PULL_DP  = 5'd21,
      A_RTS      = 5'd22,
      A_RTL      = 5'd23,
      A_RTI      = 5'd24,
      A_MVN      = 5'd25,
      A_MVP      = 5'd26
   } addressing_type;

endpackage

// File: rtl/operand_state_sequencer_pkg.sv
// Sequencer-local constants and helpers layered on top of the shared CPU types.
package operand_state_sequencer_pkg;
   import cpu_pkg::*;

   localparam logic [1:0] ByteCntMax = 2'd3;

   // States whose exit moves one operand, bank or stack byte.
   function automatic logic is_xfer_state(state_type s);
      return s inside {S_FETCH_OPRAND_L, S_FETCH_OPRAND_H, S_FETCH_OPRAND_B,
                       S_FETCH_BANK_1, S_FETCH_BANK_2,
                       S_PUSH_H, S_PUSH_L,
                       S_PULL_P, S_PULL_L, S_PULL_H, S_PULL_B};
   endfunction

   function automatic logic [1:0] sat_inc(logic [1:0] cnt);
      return (cnt == ByteCntMax) ? cnt : cnt + 2'd1;
   endfunction

endpackage

// File: rtl/operand_state_sequencer_if.sv
// Control bundle between the opcode front end (master) and the sequencer (slave).
interface operand_state_sequencer_if;
   import cpu_pkg::*;

   logic           start;
   addressing_type addressing;
   state_type      first_state;
   logic           m8;
   logic           x8;
   logic           e;
   logic           rdy;
   logic           abort;
   state_type      state;
   logic           busy;
   logic           done;
   logic [1:0]     byte_cnt;

   modport master (
      output start, addressing, first_state, m8, x8, e, rdy, abort,
      input  state, busy, done, byte_cnt
   );

   modport slave (
      input  start, addressing, first_state, m8, x8, e, rdy, abort,
      output state, busy, done, byte_cnt
   );

endinterface

// File: rtl/next_state_detector.sv
// Pure next-state table; rdy/abort gating and start handling live in the top.
module next_state_detector
   import cpu_pkg::*;
(
   input  state_type      state_i,
   input  addressing_type addressing_i,
   input  logic           m8_i,
   input  logic           x8_i,
   input  logic           e_i,
   output state_type      next_state_o
);

   logic has_high_byte;
   logic has_bank_byte;
   logic pull_is_16;
   logic pull_has_bank;

   always_comb begin
      has_high_byte = addressing_i inside {A_ABS, A_ABSX, A_ABSY, A_ABS_JMP,
                                           A_ABSL, A_ABSLX, A_ABSL_JMP,
                                           A_SUB_IMM, A_SUB_IMML, A_SUB_ABSX,
                                           A_PEA, A_PER};
      has_bank_byte = addressing_i inside {A_ABSL, A_ABSLX, A_ABSL_JMP, A_SUB_IMML};
      pull_is_16    = ((addressing_i == A_PULL_A) && !m8_i) ||
                      ((addressing_i inside {A_PULL_X, A_PULL_Y}) && !x8_i) ||
                      (addressing_i inside {A_PULL_DP, A_RTS, A_RTL, A_RTI});
      // Native-mode RTI also restores the program bank.
      pull_has_bank = (addressing_i == A_RTL) || ((addressing_i == A_RTI) && !e_i);
   end

   always_comb begin
      next_state_o = S_FETCH_OPCODE;
      unique case (state_i)
         S_FETCH_OPRAND_L: next_state_o = has_high_byte ? S_FETCH_OPRAND_H : S_OP_CALC;
         S_FETCH_OPRAND_H: next_state_o = has_bank_byte ? S_FETCH_OPRAND_B : S_OP_CALC;
         S_FETCH_OPRAND_B: next_state_o = S_OP_CALC;
         S_FETCH_BANK_1:   next_state_o = S_FETCH_BANK_2;
         S_FETCH_BANK_2:   next_state_o = S_OP_CALC;
         S_PC_INC:         next_state_o = S_OP_CALC;
         S_PUSH_H:         next_state_o = S_PUSH_L;
         S_PUSH_L:         next_state_o = S_OP_CALC;
         S_PULL_P:         next_state_o = S_PULL_L;
         S_PULL_L:         next_state_o = pull_is_16 ? S_PULL_H : S_OP_CALC;
         S_PULL_H:         next_state_o = pull_has_bank ? S_PULL_B : S_OP_CALC;
         S_PULL_B:         next_state_o = S_OP_CALC;
         S_OP_CALC:        next_state_o = S_FETCH_OPCODE;
         default:          next_state_o = S_FETCH_OPCODE;
      endcase
   end

endmodule

// File: rtl/operand_state_sequencer.sv
// Operand/stack byte sequencer: holds controller state, done pulse and byte counter.
module operand_state_sequencer
   import cpu_pkg::*;
   import operand_state_sequencer_pkg::*;
(
   input logic                       clk_i,
   input logic                       reset_i,
   operand_state_sequencer_if.slave  ctl
);

   state_type  state_q, state_d;
   state_type  table_next;
   logic       done_q, done_d;
   logic [1:0] byte_cnt_q, byte_cnt_d;

   next_state_detector u_next_state_detector (
      .state_i      (state_q),
      .addressing_i (ctl.addressing),
      .m8_i         (ctl.m8),
      .x8_i         (ctl.x8),
      .e_i          (ctl.e),
      .next_state_o (table_next)
   );

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q    <= S_FETCH_OPCODE;
         done_q     <= 1'b0;
         byte_cnt_q <= 2'd0;
      end else begin
         state_q    <= state_d;
         done_q     <= done_d;
         byte_cnt_q <= byte_cnt_d;
      end
   end

   // Abort beats both start and OP_CALC completion, and ignores rdy.
   always_comb begin
      state_d    = state_q;
      byte_cnt_d = byte_cnt_q;
      done_d     = 1'b0;
      if (ctl.abort) begin
         state_d    = S_FETCH_OPCODE;
         byte_cnt_d = 2'd0;
      end else if (ctl.rdy) begin
         if (state_q == S_FETCH_OPCODE) begin
            if (ctl.start) begin
               state_d    = ctl.first_state;
               byte_cnt_d = 2'd0;
            end
         end else begin
            state_d = table_next;
            if (is_xfer_state(state_q)) begin
               byte_cnt_d = sat_inc(byte_cnt_q);
            end
            if (state_q == S_OP_CALC) begin
               done_d = 1'b1;
            end
         end
      end
   end

   always_comb begin
      ctl.state    = state_q;
      ctl.busy     = (state_q != S_FETCH_OPCODE);
      ctl.done     = done_q;
      ctl.byte_cnt = byte_cnt_q;
   end

endmodule

// File: tb/tb_operand_state_sequencer.sv
// Directed scoreboard bench: stimulus queues per-edge expectations, a monitor checks them.
module tb_operand_state_sequencer;
   import cpu_pkg::*;

   typedef struct {
      state_type  st;
      logic       dn;
      logic [1:0] cnt;
      string      nm;
   } exp_t;

   logic clk;
   logic reset;
   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_fail = 0;
   bit   stim_done = 1'b0;

   operand_state_sequencer_if ctl ();

   operand_state_sequencer dut (
      .clk_i   (clk),
      .reset_i (reset),
      .ctl     (ctl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Monitor: one expectation per edge, checked 1ns after the edge.
   initial begin
      exp_t x;
      logic want_busy;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            want_busy = (x.st != S_FETCH_OPCODE);
            n_vec++;
            if (ctl.state !== x.st || ctl.done !== x.dn || ctl.byte_cnt !== x.cnt ||
                ctl.busy !== want_busy) begin
               n_fail++;
               $display("FAIL %s: got state=%s done=%b cnt=%0d busy=%b, want state=%s done=%b cnt=%0d busy=%b",
                        x.nm, ctl.state.name(), ctl.done, ctl.byte_cnt, ctl.busy,
                        x.st.name(), x.dn, x.cnt, want_busy);
            end
         end
      end
   end

   task automatic setup(input addressing_type a, input state_type f,
                        input logic m8, input logic x8, input logic e);
      ctl.addressing  = a;
      ctl.first_state = f;
      ctl.m8          = m8;
      ctl.x8          = x8;
      ctl.e           = e;
   endtask

   // Drive one cycle of control inputs and queue the state expected after the edge.
   task automatic cyc(input logic st, input logic rd, input logic ab, input logic rs,
                      input state_type es, input logic ed, input logic [1:0] ec,
                      input string nm);
      exp_t x;
      @(negedge clk);
      ctl.start = st;
      ctl.rdy   = rd;
      ctl.abort = ab;
      reset     = rs;
      x.st = es; x.dn = ed; x.cnt = ec; x.nm = nm;
      exp_q.push_back(x);
   endtask

   initial begin
      reset = 1'b1;
      ctl.start = 1'b0; ctl.rdy = 1'b0; ctl.abort = 1'b0;
      setup(A_WAIT, S_FETCH_OPCODE, 1'b1, 1'b1, 1'b1);

      cyc(1, 1, 1, 1, S_FETCH_OPCODE, 0, 0, "reset0");
      cyc(0, 1, 0, 1, S_FETCH_OPCODE, 0, 0, "reset1");

      // Long absolute: L, H, B, OP_CALC
      setup(A_ABSL, S_FETCH_OPRAND_L, 1'b1, 1'b1, 1'b1);
      cyc(1, 1, 0, 0, S_FETCH_OPRAND_L, 0, 0, "absl_load");
      cyc(0, 1, 0, 0, S_FETCH_OPRAND_H, 0, 1, "absl_h");
      cyc(0, 1, 0, 0, S_FETCH_OPRAND_B, 0, 2, "absl_b");
      cyc(0, 1, 0, 0, S_OP_CALC,        0, 3, "absl_calc");
      cyc(0, 1, 0, 0, S_FETCH_OPCODE,   1, 3, "absl_done");
      cyc(0, 1, 0, 0, S_FETCH_OPCODE,   0, 3, "absl_done_drop");

      // 8-bit vs 16-bit accumulator pull
      setup(A_PULL_A, S_PULL_L, 1'b1, 1'b1, 1'b1);
      cyc(1, 1, 0, 0, S_PULL_L,       0, 0, "pla8_load");
      cyc(0, 1, 0, 0, S_OP_CALC,      0, 1, "pla8_calc");
      cyc(0, 1, 0, 0, S_FETCH_OPCODE, 1, 1, "pla8_done");
      setup(A_PULL_A, S_PULL_L, 1'b0, 1'b1, 1'b1);
      cyc(1, 1, 0, 0, S_PULL_L,       0, 0, "pla16_load");
      cyc(0, 1, 0, 0, S_PULL_H,       0, 1, "pla16_h");
      cyc(0, 1, 0, 0, S_OP_CALC,      0, 2, "pla16_calc");
      cyc(0, 1, 0, 0, S_FETCH_OPCODE, 1, 2, "pla16_done");

      // 8-bit index pull stops after one byte
      setup(A_PULL_X, S_PULL_L, 1'b0, 1'b1, 1'b0);
      cyc(1, 1, 0, 0, S_PULL_L,       0, 0, "plx8_load");
      cyc(0, 1, 0, 0, S_OP_CALC,      0, 1, "plx8_calc");
      cyc(0, 1, 0, 0, S_FETCH_OPCODE, 1, 1, "plx8_done");

      // RTI native: P, L, H, B (counter saturates at 3)
      setup(A_RTI, S_PULL_P, 1'b1, 1'b1, 1'b0);
      cyc(1, 1, 0, 0, S_PULL_P,       0, 0, "rti_n_load");
      cyc(0, 1, 0, 0, S_PULL_L,       0, 1, "rti_n_l");
      cyc(0, 1, 0, 0, S_PULL_H,       0, 2, "rti_n_h");
      cyc(0, 1, 0, 0, S_PULL_B,       0, 3, "rti_n_b");
      cyc(0, 1, 0, 0, S_OP_CALC,      0, 3, "rti_n_sat");
      cyc(0, 1, 0, 0, S_FETCH_OPCODE, 1, 3, "rti_n_done");
      // RTI emulation skips PULL_B
      setup(A_RTI, S_PULL_P, 1'b1, 1'b1, 1'b1);
      cyc(1, 1, 0, 0, S_PULL_P,       0, 0, "rti_e_load");
      cyc(0, 1, 0, 0, S_PULL_L,       0, 1, "rti_e_l");
      cyc(0, 1, 0, 0, S_PULL_H,       0, 2, "rti_e_h");
      cyc(0, 1, 0, 0, S_OP_CALC,      0, 3, "rti_e_calc");
      cyc(0, 1, 0, 0, S_FETCH_OPCODE, 1, 3, "rti_e_done");

      // Block move with two wait states in BANK_2; done drops even with rdy=0
      setup(A_MVN, S_FETCH_BANK_1, 1'b1, 1'b1, 1'b1);
      cyc(1, 0, 0, 0, S_FETCH_OPCODE, 0, 3, "start_no_rdy");
      cyc(1, 1, 0, 0, S_FETCH_BANK_1, 0, 0, "mvn_load");
      cyc(0, 1, 0, 0, S_FETCH_BANK_2, 0, 1, "mvn_b2");
      cyc(0, 0, 0, 0, S_FETCH_BANK_2, 0, 1, "mvn_hold1");
      cyc(0, 0, 0, 0, S_FETCH_BANK_2, 0, 1, "mvn_hold2");
      cyc(0, 1, 0, 0, S_OP_CALC,      0, 2, "mvn_calc");
      cyc(0, 1, 0, 0, S_FETCH_OPCODE, 1, 2, "mvn_done");
      cyc(0, 0, 0, 0, S_FETCH_OPCODE, 0, 2, "mvn_done_drop");

      // Abort in OPRAND_H without rdy, then abort+start in OP_CALC
      setup(A_ABS, S_FETCH_OPRAND_L, 1'b1, 1'b1, 1'b1);
      cyc(1, 1, 0, 0, S_FETCH_OPRAND_L, 0, 0, "abs_load");
      cyc(0, 1, 0, 0, S_FETCH_OPRAND_H, 0, 1, "abs_h");
      cyc(0, 0, 1, 0, S_FETCH_OPCODE,   0, 0, "abort_in_h");
      cyc(1, 1, 0, 0, S_FETCH_OPRAND_L, 0, 0, "abs2_load");
      cyc(0, 1, 0, 0, S_FETCH_OPRAND_H, 0, 1, "abs2_h");
      cyc(0, 1, 0, 0, S_OP_CALC,        0, 2, "abs2_calc");
      cyc(1, 1, 1, 0, S_FETCH_OPCODE,   0, 0, "abort_in_calc");
      cyc(0, 1, 0, 0, S_FETCH_OPCODE,   0, 0, "abort_no_done");

      // Reset mid push, then a clean restart
      setup(A_PUSH_DP, S_PUSH_H, 1'b1, 1'b1, 1'b1);
      cyc(1, 1, 0, 0, S_PUSH_H,       0, 0, "pei_load");
      cyc(0, 1, 0, 0, S_PUSH_L,       0, 1, "pei_l");
      cyc(1, 1, 1, 1, S_FETCH_OPCODE, 0, 0, "reset_mid_push");
      cyc(1, 1, 0, 0, S_PUSH_H,       0, 0, "pei2_load");
      cyc(0, 1, 0, 0, S_PUSH_L,       0, 1, "pei2_l");
      cyc(0, 1, 0, 0, S_OP_CALC,      0, 2, "pei2_calc");
      cyc(0, 1, 0, 0, S_FETCH_OPCODE, 1, 2, "pei2_done");

      // Direct page: single operand byte
      setup(A_DP, S_FETCH_OPRAND_L, 1'b1, 1'b1, 1'b1);
      cyc(1, 1, 0, 0, S_FETCH_OPRAND_L, 0, 0, "dp_load");
      cyc(0, 1, 0, 0, S_OP_CALC,        0, 1, "dp_calc");
      cyc(0, 1, 0, 0, S_FETCH_OPCODE,   1, 1, "dp_done");

      // PC_INC moves no byte
      setup(A_IMP, S_PC_INC, 1'b1, 1'b1, 1'b1);
      cyc(1, 1, 0, 0, S_PC_INC,       0, 0, "pcinc_load");
      cyc(0, 1, 0, 0, S_OP_CALC,      0, 0, "pcinc_calc");
      cyc(0, 1, 0, 0, S_FETCH_OPCODE, 1, 0, "pcinc_done");

      // A_WAIT stays in fetch but still clears the counter
      setup(A_SUB_IMML, S_FETCH_OPRAND_L, 1'b1, 1'b1, 1'b1);
      cyc(1, 1, 0, 0, S_FETCH_OPRAND_L, 0, 0, "imml_load");
      cyc(0, 1, 0, 0, S_FETCH_OPRAND_H, 0, 1, "imml_h");
      cyc(0, 1, 0, 0, S_FETCH_OPRAND_B, 0, 2, "imml_b");
      cyc(0, 1, 0, 0, S_OP_CALC,        0, 3, "imml_calc");
      cyc(0, 1, 0, 0, S_FETCH_OPCODE,   1, 3, "imml_done");
      setup(A_WAIT, S_FETCH_OPCODE, 1'b1, 1'b1, 1'b1);
      cyc(1, 1, 0, 0, S_FETCH_OPCODE,   0, 0, "wait_start");

      cyc(0, 0, 0, 0, S_FETCH_OPCODE,   0, 0, "idle_end");
      stim_done = 1'b1;
   end

   initial begin
      wait (stim_done);
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending expectations, want 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no end of stimulus, want completion before 100us");
      $fatal(1, "timeout");
   end

endmodule
